// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: one outstanding imem request at a time, returned
// words tagged with their PC and buffered in a small FIFO toward decode.
module ifetch_queue #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pc,
    input  logic         flush,
    output logic         pc_stall,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [W-1:0] imem_rdata,
    output logic         id_valid,
    input  logic         id_ready,
    output logic [W-1:0] id_pc,
    output logic [W-1:0] id_inst
);

    typedef enum logic [1:0] {IDLE, WAIT_DATA, DRAIN} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    state_t           state_q, state_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [W-1:0]     req_pc_q, req_pc_d;
    logic [W-1:0]     pc_mem_q   [DEPTH];
    logic [W-1:0]     inst_mem_q [DEPTH];

    logic fire;
    logic push;
    logic pop;

    // Reset is folded in so the request and stall outputs are correct while rst is held.
    assign imem_req  = !rst && (state_q == IDLE) && (count_q < FULL_CNT) && !flush;
    assign imem_addr = pc;
    assign fire      = imem_req && imem_gnt;
    assign pc_stall  = rst || !(fire || flush);

    assign id_valid = (count_q != '0);
    assign id_pc    = pc_mem_q[rd_ptr_q];
    assign id_inst  = inst_mem_q[rd_ptr_q];

    assign push = (state_q == WAIT_DATA) && imem_rvalid && !flush;
    assign pop  = id_valid && id_ready;

    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    req_pc_d = pc;
                    state_d  = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            req_pc_q <= req_pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
            inst_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: a request/response reference model feeds an
// expected-entry queue that a negedge monitor compares against the decode port.
module tb_ifetch_queue;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pc;
    logic         flush;
    logic         pc_stall;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [W-1:0] imem_rdata;
    logic         id_valid;
    logic         id_ready;
    logic [W-1:0] id_pc;
    logic [W-1:0] id_inst;

    ifetch_queue #(.W(W), .DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .flush       (flush),
        .pc_stall    (pc_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_inst     (id_inst)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: fetched entries in decode order, plus the fate of the one
    // outstanding request (none / live / cancelled by a flush).
    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] inst;
    } entry_t;

    entry_t       exp_q[$];
    int           req_fate;       // 0 none, 1 live, 2 cancelled
    logic [W-1:0] req_addr;
    bit           model_on = 0;

    always @(negedge clk) begin
        if (model_on && !rst) begin
            logic exp_req;
            exp_req = (req_fate == 0) && (exp_q.size() < DEPTH) && !flush;
            chk("imem_req", W'(imem_req), W'(exp_req));
            chk("pc_stall", W'(pc_stall), W'(!((exp_req && imem_gnt) || flush)));
            if (exp_req) chk("imem_addr", imem_addr, pc);
            chk("id_valid", W'(id_valid), W'(exp_q.size() != 0));
            if (exp_q.size() != 0 && id_valid) begin
                chk("id_pc", id_pc, exp_q[0].pc);
                chk("id_inst", id_inst, exp_q[0].inst);
            end
            if (exp_q.size() != 0 && id_ready) void'(exp_q.pop_front());
            case (req_fate)
                0: if (exp_req && imem_gnt) begin
                       req_fate = 1;
                       req_addr = pc;
                   end
                1: if (imem_rvalid) begin
                       if (!flush) exp_q.push_back('{pc: req_addr, inst: imem_rdata});
                       req_fate = 0;
                   end else if (flush) begin
                       req_fate = 2;
                   end
                default: if (imem_rvalid) req_fate = 0;
            endcase
            if (flush) exp_q.delete();
        end
    end

    task automatic step(input int p_gnt, input int p_rv, input int p_rdy, input int p_fl);
        @(posedge clk);
        #1;
        pc          = {$urandom_range(32'h3FFF), 2'b00};
        imem_gnt    = ($urandom_range(99) < p_gnt);
        imem_rvalid = ($urandom_range(99) < p_rv);
        imem_rdata  = $urandom;
        id_ready    = ($urandom_range(99) < p_rdy);
        flush       = ($urandom_range(99) < p_fl);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_imem_req"}, W'(imem_req), '0);
        chk({tag, "_pc_stall"}, W'(pc_stall), W'(1));
        chk({tag, "_id_valid"}, W'(id_valid), '0);
        chk({tag, "_id_pc"}, id_pc, '0);
        chk({tag, "_id_inst"}, id_inst, '0);
    endtask

    initial begin
        rst = 1'b1; pc = '0; flush = 0; imem_gnt = 0; imem_rvalid = 0;
        imem_rdata = '0; id_ready = 0;
        req_fate = 0; req_addr = '0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst_init");
        @(posedge clk);
        #3 rst = 1'b0;
        model_on = 1;

        // single fetch of 0x100 with immediate pop
        @(posedge clk); #1;
        pc = 32'h100; imem_gnt = 1; id_ready = 1;
        @(posedge clk); #1;
        imem_gnt = 0; pc = 32'h104;
        @(posedge clk); #1;
        imem_rvalid = 1; imem_rdata = 32'h2402_0005;
        @(posedge clk); #1;
        imem_rvalid = 0;
        repeat (2) @(posedge clk);

        // fill the queue with decode stalled, then drain with full throughput
        #1 id_ready = 0; imem_gnt = 1; imem_rvalid = 1;
        for (int i = 0; i < 14; i++) begin
            pc = W'(i * 4);
            @(posedge clk); #1;
        end
        id_ready = 1;
        repeat (12) @(posedge clk);

        repeat (400) step(60, 50, 60, 3);
        repeat (150) step(80, 80, 10, 2);
        repeat (150) step(90, 90, 95, 0);
        repeat (200) step(70, 40, 50, 15);

        // asynchronous reset while a request is outstanding
        repeat (4) @(posedge clk);
        #1 id_ready = 1; flush = 0; imem_gnt = 0; imem_rvalid = 0;
        repeat (6) @(posedge clk);
        #1 imem_gnt = 1; pc = 32'h400;
        @(posedge clk); #1;
        imem_gnt = 0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        exp_q.delete();
        req_fate = 0;
        @(posedge clk);
        #3 rst = 1'b0;
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        imem_rvalid = 0;

        repeat (400) step(60, 50, 60, 5);
        @(negedge clk);
        model_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits between the PC stage and the decode stage.
- Issues one instruction-memory request per granted PC and tags each returned word with its PC.
- Buffers fetched {pc, inst} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Back-pressures the PC stage through pc_stall and discards all in-flight and queued work on a branch flush.

Parameters:
W, 32, word/address width
DEPTH, 4, FIFO entries (power of 2, >=2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
pc  in  W  current PC from the PC stage
flush  in  1  branch redirect: drop outstanding fetch and all queued entries
pc_stall  out  1  to PC stage: 1 = hold PC, 0 = PC may advance this cycle
imem_req  out  1  fetch request valid
imem_addr  out  W  fetch address, equal to pc
imem_gnt  in  1  memory accepted the request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  W  instruction word
id_valid  out  1  head entry valid to decode
id_ready  in  1  decode accepts head entry
id_pc  out  W  PC of head entry
id_inst  out  W  instruction of head entry

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high; every register clears immediately on assertion.
- Reset values:
  - state = IDLE, count = 0, rd_ptr = wr_ptr = 0, storage = 0.
  - imem_req = 0, id_valid = 0, id_pc = 0, id_inst = 0, pc_stall = 1.
- At most one outstanding memory request at any time.
- FSM states:
  - IDLE: imem_req = (count < DEPTH) && !flush; imem_addr = pc. If imem_req && imem_gnt, latch pc into req_pc and go to WAIT_DATA.
  - WAIT_DATA: imem_req = 0. On imem_rvalid, push {req_pc, imem_rdata} and go to IDLE. On flush without rvalid, go to DRAIN. On flush with rvalid in the same cycle, drop the data and go to IDLE.
  - DRAIN: imem_req = 0. On imem_rvalid, discard the data and go to IDLE. A further flush stays in DRAIN.
- pc_stall:
  - pc_stall = 0 exactly in the cycle where imem_req && imem_gnt, or where flush = 1 (so the PC stage loads the redirect target); otherwise 1.
  - Forced to 1 while rst is asserted.
- Flush and grant in the same cycle: imem_req is already 0 because of flush, so no grant can be accepted. A stray imem_gnt while imem_req = 0 is ignored.
- FIFO:
  - Push only from WAIT_DATA on rvalid. Space is guaranteed because requests are only issued when count < DEPTH, so overflow is impossible.
  - Pop when id_valid && id_ready. id_valid = (count != 0).
  - id_pc/id_inst are read combinationally from storage[rd_ptr].
  - Simultaneous push and pop leaves count unchanged and advances both pointers.
  - Pointers wrap modulo DEPTH.
- Flush on the FIFO: count, rd_ptr and wr_ptr clear to 0 at the next edge. A pop in the flush cycle is still considered consumed by decode. Any push in the flush cycle is suppressed.
- Stray response: imem_rvalid in IDLE is ignored (protocol error, no state change).
- Throughput:
  - Minimum 2 cycles per fetch (grant, then rvalid no earlier than the next cycle).
  - A new request may be issued in the cycle after the push.
- Reset mid-operation: any state returns to IDLE immediately. A memory response arriving after rst deasserts lands in IDLE and is ignored.

Test Plan:
- Release reset, pc=0x100, gnt=1, rvalid 2 cycles later with rdata=0x2402_0005, id_ready=1 -> pc_stall=0 for exactly 1 cycle; id_valid=1 with id_pc=0x100, id_inst=0x24020005; popped the same cycle.
- id_ready=0, pc stepping 0x0,0x4,0x8,0xC,0x10, gnt/rvalid always 1 -> 4 entries queued; imem_req stays 0 afterwards and pc_stall stays 1. Then set id_ready=1 -> entries pop in order 0x0..0xC, and fetch of 0x10 resumes after the first pop.
- Flush asserted in WAIT_DATA, rvalid arrives 3 cycles later -> FSM goes DRAIN, data is discarded, id_valid=0, and the next request uses the new pc=0x400.
- Flush asserted in the same cycle as rvalid with 2 entries queued -> queue empties, the response is not pushed, id_valid=0 on the next cycle.
- Queue holding 3 entries, push and pop in the same cycle -> count stays 3, head advances, and wr_ptr wraps from 3 to 0 correctly.
- Assert rst mid-WAIT_DATA between clock edges -> outputs drop to reset values immediately (asynchronous), and a late rvalid after release produces no entry.
